// File: rtl/dice_roller.sv
// Purpose: draws a value in [MIN_VAL, MAX_VAL] from a free-running random source by rejection sampling.
// Latency: roll_req to roll_valid takes 1+k cycles, where k (1..MAX_TRIES) is the number of samples examined.
// Backpressure: the result is held until roll_ack; roll_req is ignored outside IDLE.
module dice_roller #(
    parameter int MIN_VAL   = 1,
    parameter int MAX_VAL   = 6,
    parameter int MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] number,
    input  logic       roll_req,
    input  logic       roll_ack,
    output logic [3:0] roll_value,
    output logic       roll_valid,
    output logic       busy,
    output logic       fallback,
    output logic [7:0] roll_count,
    output logic [7:0] reject_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    localparam logic [3:0] LO   = 4'(MIN_VAL);
    localparam logic [3:0] HI   = 4'(MAX_VAL);
    localparam logic [3:0] LAST = 4'(MAX_TRIES - 1);

    logic [1:0] state;
    logic [3:0] tries;
    logic       in_range;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_range   = (number >= LO) && (number <= HI);
    assign busy       = (state == SAMPLE);
    assign roll_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tries        <= 4'd0;
            roll_value   <= 4'd0;
            fallback     <= 1'b0;
            roll_count   <= 8'd0;
            reject_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (roll_req) begin
                        state <= SAMPLE;
                        tries <= 4'd0;
                    end
                end
                SAMPLE: begin
                    if (in_range) begin
                        roll_value <= number;
                        fallback   <= 1'b0;
                        state      <= HOLD;
                        roll_count <= sat_inc(roll_count);
                    end else if (tries == LAST) begin
                        // Out of tries: deliver the lowest legal value so the consumer never stalls.
                        roll_value   <= LO;
                        fallback     <= 1'b1;
                        state        <= HOLD;
                        roll_count   <= sat_inc(roll_count);
                        reject_count <= sat_inc(reject_count);
                    end else begin
                        tries        <= tries + 4'd1;
                        reject_count <= sat_inc(reject_count);
                    end
                end
                HOLD: begin
                    if (roll_ack) begin
                        state    <= IDLE;
                        fallback <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: expected rolls are queued when requested and checked when roll_valid rises.
module tb_dice_roller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] number;
    logic       roll_req;
    logic       roll_ack;
    logic [3:0] roll_value;
    logic       roll_valid;
    logic       busy;
    logic       fallback;
    logic [7:0] roll_count;
    logic [7:0] reject_count;

    dice_roller #(.MIN_VAL(1), .MAX_VAL(6), .MAX_TRIES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .number      (number),
        .roll_req    (roll_req),
        .roll_ack    (roll_ack),
        .roll_value  (roll_value),
        .roll_valid  (roll_valid),
        .busy        (busy),
        .fallback    (fallback),
        .roll_count  (roll_count),
        .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] val;
        logic       fb;
        int         lat;
        logic [7:0] rc;
        logic [7:0] jc;
        bit         any;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] nseq[$];
    bit         rnd_mode = 1'b0;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) number = 4'($urandom_range(15, 0));
    endtask

    task automatic push(input logic [3:0] val, input logic fb, input int lat,
                        input logic [7:0] rc, input logic [7:0] jc, input bit any);
        exp_t e;
        e.val = val; e.fb = fb; e.lat = lat; e.rc = rc; e.jc = jc; e.any = any;
        sb.push_back(e);
    endtask

    task automatic roll(input bit req_with_ack);
        exp_t e;
        int   lat;
        roll_req = 1'b1;
        if (!rnd_mode && nseq.size() > 0) number = nseq.pop_front();
        step();
        lat = 1;
        roll_req = 1'b0;
        check("busy_after_req", busy, 1);
        while (!roll_valid && lat < 20) begin
            step();
            lat++;
            if (!rnd_mode && nseq.size() > 0) number = nseq.pop_front();
        end
        if (!roll_valid) begin
            check("valid_timeout", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("busy_in_hold", busy, 0);
        if (e.any) begin
            check("value_in_range", (roll_value >= 4'd1) && (roll_value <= 4'd6), 1);
            check("latency_bound", (lat >= 2) && (lat <= 9), 1);
        end else begin
            check("roll_value", roll_value, e.val);
            check("fallback", fallback, e.fb);
            check("latency", lat, e.lat);
            check("roll_count", roll_count, e.rc);
            check("reject_count", reject_count, e.jc);
        end
        roll_ack = 1'b1;
        roll_req = req_with_ack;
        step();
        roll_ack = 1'b0;
        roll_req = 1'b0;
        check("valid_after_ack", roll_valid, 0);
        check("fallback_after_ack", fallback, 0);
        if (!e.any) check("value_kept_after_ack", roll_value, e.val);
        if (req_with_ack) begin
            step();
            check("no_roll_from_ack_req", busy, 0);
            check("still_idle_valid", roll_valid, 0);
        end
    endtask

    initial begin
        logic [7:0] rc;

        rst      = 1'b1;
        roll_req = 1'b1;
        roll_ack = 1'b0;
        number   = 4'd4;
        for (int i = 0; i < 10; i++) step();
        check("rst_value", roll_value, 0);
        check("rst_valid", roll_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fallback", fallback, 0);
        check("rst_roll_count", roll_count, 0);
        check("rst_reject_count", reject_count, 0);
        rst      = 1'b0;
        roll_req = 1'b0;
        step();
        step();
        check("no_roll_after_rst_busy", busy, 0);
        check("no_roll_after_rst_valid", roll_valid, 0);

        // First-sample hit.
        number = 4'd4;
        push(4'd4, 1'b0, 2, 8'd1, 8'd0, 1'b0);
        roll(1'b0);

        // Three rejects then a hit.
        nseq = '{4'd0, 4'd9, 4'd15, 4'd3};
        push(4'd3, 1'b0, 5, 8'd2, 8'd3, 1'b0);
        roll(1'b0);

        // Never in range: timeout delivers MIN_VAL with fallback.
        number = 4'd0;
        push(4'd1, 1'b1, 9, 8'd3, 8'd11, 1'b0);
        roll(1'b0);

        // Upper boundary value, acked together with a new request.
        number = 4'd6;
        push(4'd6, 1'b0, 2, 8'd4, 8'd11, 1'b0);
        roll(1'b1);

        // Reset mid-SAMPLE discards the roll and clears counters.
        number   = 4'd0;
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        step();
        step();
        check("mid_sample_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_valid", roll_valid, 0);
        check("midrst_value", roll_value, 0);
        check("midrst_roll_count", roll_count, 0);
        check("midrst_reject_count", reject_count, 0);
        step();
        check("midrst_stays_idle", busy, 0);

        // Saturation of roll_count.
        number = 4'd2;
        rc = 8'd0;
        for (int i = 0; i < 300; i++) begin
            rc = (rc == 8'hFF) ? rc : rc + 8'd1;
            push(4'd2, 1'b0, 2, rc, 8'd0, 1'b0);
            roll(1'b0);
        end
        check("roll_count_saturated", roll_count, 255);

        // Free-running random source.
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(4'd0, 1'b0, 0, 8'd0, 8'd0, 1'b1);
            roll(1'b0);
        end
        rnd_mode = 1'b0;
        check("roll_count_stays_saturated", roll_count, 255);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 SHALL have parameter MIN_VAL, default 1, lowest accepted value (4-bit).
REQ-002 SHALL have parameter MAX_VAL, default 6, highest accepted value (4-bit, MIN_VAL <= MAX_VAL <= 15).
REQ-003 SHALL have parameter MAX_TRIES, default 8, samples examined per roll before fallback (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port number  input  4  free-running pseudo-random value from the upstream random counter, new value each cycle.
REQ-007 SHALL have port roll_req  input  1  request a roll; sampled only in IDLE.
REQ-008 SHALL have port roll_ack  input  1  consumer acknowledges the held result; sampled only in HOLD.
REQ-009 SHALL have port roll_value  output  4  captured result.
REQ-010 SHALL have port roll_valid  output  1  high while roll_value holds an unacknowledged result.
REQ-011 SHALL have port busy  output  1  high in SAMPLE.
REQ-012 SHALL have port fallback  output  1  high with roll_valid when the result came from timeout.
REQ-013 SHALL have port roll_count  output  8  completed rolls, saturating.
REQ-014 SHALL have port reject_count  output  8  out-of-range samples discarded, saturating.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, SAMPLE, HOLD.
REQ-016 IDLE: roll_req=1 at an edge SHALL move to SAMPLE and clear the try counter; roll_ack ignored.
REQ-017 SAMPLE: each cycle number SHALL be tested against MIN_VAL <= number <= MAX_VAL (unsigned).
REQ-018 SAMPLE, in range: roll_value <= number, fallback <= 0, go to HOLD, roll_count increments.
REQ-019 SAMPLE, out of range and tries < MAX_TRIES-1: tries increments, reject_count increments, stay in SAMPLE.
REQ-020 SAMPLE, out of range and tries == MAX_TRIES-1: roll_value <= MIN_VAL, fallback <= 1, go to HOLD, reject_count and roll_count increment.
REQ-021 roll_req and roll_ack in SAMPLE SHALL be ignored.
REQ-022 HOLD: roll_valid=1, roll_value and fallback stable; roll_ack=1 at an edge SHALL go to IDLE, with roll_valid and fallback cleared in the same update.
REQ-023 roll_req in the same cycle as roll_ack SHALL be ignored; a new roll needs roll_req while in IDLE.
REQ-024 Latency: roll_req edge -> roll_valid high after 1+k cycles, k = samples examined (1..MAX_TRIES); minimum 2 cycles.
REQ-025 roll_value SHALL keep its last value after ack until the next capture.
REQ-026 roll_count and reject_count SHALL saturate at 255 and never wrap.
REQ-027 busy SHALL be a decode of state SAMPLE; roll_valid a decode of HOLD (registered state, no combinational path from inputs).

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, roll_value=0, roll_valid=0, busy=0, fallback=0, roll_count=0, reject_count=0, tries=0.
REQ-029 rst SHALL take priority over all inputs in any state, including mid-SAMPLE and HOLD; any pending roll is discarded.
REQ-030 Outputs SHALL be unknown-free from the first edge with rst=1.

Verification
REQ-031 rst high 10 cycles -> all outputs 0, state IDLE; hold roll_req=1 during reset -> no roll started.
REQ-032 number=4 constant, roll_req pulse -> busy 1 cycle, roll_valid=1 two cycles after req, roll_value=4, fallback=0, roll_count=1, reject_count=0.
REQ-033 number sequence 0,9,15,3 after req -> roll_value=3, reject_count=3, valid 5 cycles after req.
REQ-034 number=0 constant, MAX_TRIES=8 -> roll_value=1, fallback=1, reject_count=8, valid 9 cycles after req.
REQ-035 In HOLD assert roll_ack and roll_req together -> IDLE, roll_valid=0, no new roll; rst asserted mid-SAMPLE -> IDLE, counters 0.
REQ-036 300 rolls with number=2 -> roll_count=255 saturated; connected to the random counter, every roll_value in 1..6.
